// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states, bus owner and fetch lane mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [3:0] SEL_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and bus signal bundle; master is the arbiter side, slave is the environment.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic        if_err_o;
  logic [31:0] if_dat_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_sel_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_dat_i;
  logic        lsu_ack_o;
  logic        lsu_err_o;
  logic [31:0] lsu_dat_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;

  modport master (
    input  if_req_i, if_addr_i,
    input  lsu_req_i, lsu_we_i, lsu_sel_i, lsu_addr_i, lsu_dat_i,
    input  dat_i, ack_i, err_i,
    output if_ack_o, if_err_o, if_dat_o,
    output lsu_ack_o, lsu_err_o, lsu_dat_o,
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output lsu_req_i, lsu_we_i, lsu_sel_i, lsu_addr_i, lsu_dat_i,
    output dat_i, ack_i, err_i,
    input  if_ack_o, if_err_o, if_dat_o,
    input  lsu_ack_o, lsu_err_o, lsu_dat_o,
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Bus-cycle watchdog: expired is high during the TIMEOUT_CYCLES-th consecutive enabled cycle.
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_reg;

  // count_reg holds the number of enabled cycles already completed
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear) begin
      count_reg <= '0;
    end else if (enable && count_reg != LAST) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto a single pipelined-less bus with timeout and anti-starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int STARVE_LIMIT   = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  mem_arbiter_if.master bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state_reg;
  owner_t        owner_reg;
  logic [SW-1:0] starve_reg;
  logic          cyc_reg;
  logic          we_reg;
  logic [3:0]    sel_reg;
  logic [31:0]   adr_reg;
  logic [31:0]   dat_reg;
  logic          if_ack_reg, if_err_reg, lsu_ack_reg, lsu_err_reg;
  logic [31:0]   if_dat_reg, lsu_dat_reg;
  logic          in_bus, expired, fetch_due, lsu_win;

  assign in_bus    = (state_reg == BUS);
  assign fetch_due = bus.if_req_i && (starve_reg == STARVE_MAX);
  assign lsu_win   = bus.lsu_req_i && !fetch_due;

  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (!in_bus),
    .enable  (in_bus),
    .expired (expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg   <= IDLE;
      owner_reg   <= OWN_IF;
      starve_reg  <= '0;
      cyc_reg     <= 1'b0;
      we_reg      <= 1'b0;
      sel_reg     <= '0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      if_ack_reg  <= 1'b0;
      if_err_reg  <= 1'b0;
      lsu_ack_reg <= 1'b0;
      lsu_err_reg <= 1'b0;
      if_dat_reg  <= '0;
      lsu_dat_reg <= '0;
    end else begin
      if_ack_reg  <= 1'b0;
      if_err_reg  <= 1'b0;
      lsu_ack_reg <= 1'b0;
      lsu_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!bus.if_req_i) starve_reg <= '0;
          if (lsu_win) begin
            owner_reg <= OWN_LSU;
            we_reg    <= bus.lsu_we_i;
            sel_reg   <= bus.lsu_sel_i;
            adr_reg   <= bus.lsu_addr_i;
            dat_reg   <= bus.lsu_dat_i;
            cyc_reg   <= 1'b1;
            state_reg <= BUS;
            if (bus.if_req_i && starve_reg != STARVE_MAX) starve_reg <= starve_reg + 1'b1;
          end else if (bus.if_req_i) begin
            owner_reg  <= OWN_IF;
            we_reg     <= 1'b0;
            sel_reg    <= SEL_ALL;
            adr_reg    <= bus.if_addr_i;
            dat_reg    <= '0;
            cyc_reg    <= 1'b1;
            state_reg  <= BUS;
            starve_reg <= '0;
          end
        end
        BUS: begin
          if (bus.err_i || bus.ack_i || expired) begin
            cyc_reg   <= 1'b0;
            state_reg <= RESP;
            // err_i beats ack_i; a bare timeout reports as an error too
            if (bus.err_i || !bus.ack_i) begin
              if (owner_reg == OWN_LSU) lsu_err_reg <= 1'b1;
              else                      if_err_reg  <= 1'b1;
            end else if (owner_reg == OWN_LSU) begin
              lsu_ack_reg <= 1'b1;
              lsu_dat_reg <= bus.dat_i;
            end else begin
              if_ack_reg <= 1'b1;
              if_dat_reg <= bus.dat_i;
            end
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cyc_o     = cyc_reg;
  assign bus.stb_o     = cyc_reg;
  assign bus.we_o      = we_reg;
  assign bus.sel_o     = sel_reg;
  assign bus.adr_o     = adr_reg;
  assign bus.dat_o     = dat_reg;
  assign bus.if_ack_o  = if_ack_reg;
  assign bus.if_err_o  = if_err_reg;
  assign bus.if_dat_o  = if_dat_reg;
  assign bus.lsu_ack_o = lsu_ack_reg;
  assign bus.lsu_err_o = lsu_err_reg;
  assign bus.lsu_dat_o = lsu_dat_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants queued at stimulus, compared on each ack/err pulse.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        lsu;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
  } req_t;

  typedef struct {
    logic        lsu;
    logic        err;
    logic [31:0] dat;
    int          cnt;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(16), .STARVE_LIMIT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;
  req_t exp_q[$];
  req_t bus_q[$];
  rsp_t got_q[$];

  // bus slave model: 0 ack, 1 silent, 2 ack+err, 3 stray ack/err outside bus cycles
  int          resp_mode = 0;
  int          resp_delay = 0;
  logic [31:0] resp_rdat = '0;
  int          wcnt = 0;
  int          last_len = 0;
  bit          unstable = 0;
  req_t        cur;
  logic [31:0] last_if_dat = '0;
  logic [31:0] last_lsu_dat = '0;

  always @(posedge clk) cyc_cnt++;

  always @(negedge clk) begin
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    bus.dat_i = 32'h0BAD_F00D;
    if (bus.cyc_o === 1'b1 && bus.stb_o === 1'b1) begin
      wcnt++;
      if (wcnt == 1) begin
        cur = '{lsu: 1'b0, we: bus.we_o, sel: bus.sel_o, adr: bus.adr_o, wdat: bus.dat_o};
        bus_q.push_back(cur);
      end else if ({bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o} !== {cur.we, cur.sel, cur.adr, cur.wdat}) begin
        unstable = 1'b1;
      end
      if (wcnt > resp_delay && (resp_mode == 0 || resp_mode == 2)) begin
        bus.ack_i = 1'b1;
        bus.err_i = (resp_mode == 2);
        bus.dat_i = resp_rdat;
      end
    end else begin
      if (wcnt > 0) last_len = wcnt;
      wcnt = 0;
      if (resp_mode == 3) begin
        bus.ack_i = 1'b1;
        bus.err_i = cyc_cnt[0];
      end
    end
  end

  always @(negedge clk) begin
    if (bus.if_ack_o === 1'b1)  got_q.push_back('{lsu: 1'b0, err: 1'b0, dat: bus.if_dat_o,  cnt: cyc_cnt});
    if (bus.if_err_o === 1'b1)  got_q.push_back('{lsu: 1'b0, err: 1'b1, dat: bus.if_dat_o,  cnt: cyc_cnt});
    if (bus.lsu_ack_o === 1'b1) got_q.push_back('{lsu: 1'b1, err: 1'b0, dat: bus.lsu_dat_o, cnt: cyc_cnt});
    if (bus.lsu_err_o === 1'b1) got_q.push_back('{lsu: 1'b1, err: 1'b1, dat: bus.lsu_dat_o, cnt: cyc_cnt});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    bus_q.delete();
    got_q.delete();
  endtask

  task automatic wait_rsp(output rsp_t r, output bit ok);
    ok = 1'b0;
    r = '{lsu: 1'b0, err: 1'b0, dat: '0, cnt: 0};
    for (int i = 0; i < 64 && !ok; i++) begin
      if (got_q.size() > 0) begin
        r = got_q.pop_front();
        ok = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  task automatic pop_bus(output req_t b);
    if (bus_q.size() > 0) b = bus_q.pop_front();
    else b = '{lsu: 1'b0, we: 1'b0, sel: 4'h0, adr: 32'hFFFF_FFFF, wdat: 32'hFFFF_FFFF};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: got cyc=%b stb=%b we=%b sel=%b adr=%h dat=%h, want all 0",
               bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o, bus.adr_o, bus.dat_o);
    end
    vectors++;
    if ({bus.if_ack_o, bus.if_err_o, bus.if_dat_o, bus.lsu_ack_o, bus.lsu_err_o, bus.lsu_dat_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: got if_ack=%b if_err=%b if_dat=%h lsu_ack=%b lsu_err=%b lsu_dat=%h, want all 0",
               bus.if_ack_o, bus.if_err_o, bus.if_dat_o, bus.lsu_ack_o, bus.lsu_err_o, bus.lsu_dat_o);
    end
    rst = 1'b1;
    tick();
    flush();
  endtask

  task automatic lsu_write_check(input string name, input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] wdat, input logic [31:0] rdat);
    req_t e, b;
    rsp_t r;
    bit   ok;
    int   t0;
    flush();
    resp_mode = 0; resp_delay = 0; resp_rdat = rdat;
    exp_q.push_back('{lsu: 1'b1, we: 1'b1, sel: sel, adr: adr, wdat: wdat});
    bus.lsu_we_i = 1'b1; bus.lsu_sel_i = sel; bus.lsu_addr_i = adr; bus.lsu_dat_i = wdat;
    bus.lsu_req_i = 1'b1;
    t0 = cyc_cnt;
    wait_rsp(r, ok);
    bus.lsu_req_i = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_rsp: got no ack/err within 64 cycles, want lsu_ack", name);
    end else begin
      e = exp_q.pop_front();
      pop_bus(b);
      vectors++;
      if ({b.we, b.sel, b.adr, b.wdat} !== {e.we, e.sel, e.adr, e.wdat}) begin
        miscompares++;
        $display("FAIL %s_bus: got we=%b sel=%b adr=%h dat=%h, want we=%b sel=%b adr=%h dat=%h",
                 name, b.we, b.sel, b.adr, b.wdat, e.we, e.sel, e.adr, e.wdat);
      end
      vectors++;
      if ({r.lsu, r.err} !== 2'b10) begin
        miscompares++;
        $display("FAIL %s_kind: got lsu=%b err=%b, want lsu=1 err=0", name, r.lsu, r.err);
      end
      vectors++;
      if (r.cnt - t0 + 1 != 3) begin
        miscompares++;
        $display("FAIL %s_latency: got %0d cycles, want 3", name, r.cnt - t0 + 1);
      end
      vectors++;
      if (r.dat !== rdat) begin
        miscompares++;
        $display("FAIL %s_rdat: got %h, want %h", name, r.dat, rdat);
      end
      last_lsu_dat = rdat;
    end
    repeat (4) tick();
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_single: got %0d extra pulses, want 0", name, got_q.size());
    end
  endtask

  task automatic test_lsu_write();
    lsu_write_check("lsu_write", 32'h100, 4'b0011, 32'hAAAA_5555, 32'h1234_5678);
  endtask

  task automatic test_fetch_read();
    req_t e, b;
    rsp_t r;
    bit   ok;
    flush();
    resp_mode = 0; resp_delay = 2; resp_rdat = 32'hDEAD_BEEF; unstable = 1'b0;
    exp_q.push_back('{lsu: 1'b0, we: 1'b0, sel: 4'b1111, adr: 32'h40, wdat: '0});
    bus.if_addr_i = 32'h40; bus.if_req_i = 1'b1;
    repeat (2) tick();
    bus.if_addr_i = 32'h44; bus.lsu_sel_i = 4'b0101; bus.lsu_dat_i = 32'h1111_2222;
    wait_rsp(r, ok);
    bus.if_req_i = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL fetch_rsp: got no ack/err within 64 cycles, want if_ack");
    end else begin
      e = exp_q.pop_front();
      pop_bus(b);
      vectors++;
      if ({b.we, b.sel, b.adr} !== {e.we, e.sel, e.adr}) begin
        miscompares++;
        $display("FAIL fetch_bus: got we=%b sel=%b adr=%h, want we=%b sel=%b adr=%h",
                 b.we, b.sel, b.adr, e.we, e.sel, e.adr);
      end
      vectors++;
      if ({r.lsu, r.err, r.dat} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
        miscompares++;
        $display("FAIL fetch_ack: got lsu=%b err=%b dat=%h, want lsu=0 err=0 dat=deadbeef", r.lsu, r.err, r.dat);
      end
      vectors++;
      if (unstable !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_stable: got bus fields changing during cycle, want stable");
      end
      last_if_dat = 32'hDEAD_BEEF;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    req_t e, b;
    rsp_t r;
    bit   ok;
    int   nl, ni;
    bit   pattern [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    flush();
    resp_mode = 0; resp_delay = 0; resp_rdat = 32'h0000_C0DE;
    nl = 0; ni = 0;
    foreach (pattern[k]) begin
      if (pattern[k]) begin
        exp_q.push_back('{lsu: 1'b1, we: 1'b0, sel: 4'hF, adr: 32'h200 + 32'(4 * nl), wdat: '0});
        nl++;
      end else begin
        exp_q.push_back('{lsu: 1'b0, we: 1'b0, sel: 4'hF, adr: 32'h80 + 32'(4 * ni), wdat: '0});
        ni++;
      end
    end
    bus.lsu_we_i = 1'b0; bus.lsu_sel_i = 4'hF; bus.lsu_addr_i = 32'h200; bus.if_addr_i = 32'h80;
    bus.lsu_req_i = 1'b1; bus.if_req_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_rsp(r, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL b2b_rsp%0d: got no ack/err within 64 cycles, want a grant", k);
        break;
      end
      e = exp_q.pop_front();
      pop_bus(b);
      vectors++;
      if ({r.lsu, b.adr} !== {e.lsu, e.adr}) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got owner_lsu=%b adr=%h, want owner_lsu=%b adr=%h", k, r.lsu, b.adr, e.lsu, e.adr);
      end
      if (r.lsu) bus.lsu_addr_i = bus.lsu_addr_i + 32'd4;
      else bus.if_addr_i = bus.if_addr_i + 32'd4;
    end
    bus.lsu_req_i = 1'b0; bus.if_req_i = 1'b0;
    last_if_dat = 32'h0000_C0DE;
    last_lsu_dat = 32'h0000_C0DE;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    rsp_t r;
    bit   ok;
    int   t0;
    flush();
    resp_mode = 1; last_len = 0;
    bus.lsu_we_i = 1'b1; bus.lsu_sel_i = 4'hF; bus.lsu_addr_i = 32'h300; bus.lsu_dat_i = 32'h7777_0000;
    bus.lsu_req_i = 1'b1;
    t0 = cyc_cnt;
    wait_rsp(r, ok);
    bus.lsu_req_i = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL timeout_rsp: got no ack/err within 64 cycles, want lsu_err");
    end else begin
      vectors++;
      if ({r.lsu, r.err} !== 2'b11) begin
        miscompares++;
        $display("FAIL timeout_kind: got lsu=%b err=%b, want lsu=1 err=1", r.lsu, r.err);
      end
      vectors++;
      if (last_len != 16 || r.cnt - t0 != 17) begin
        miscompares++;
        $display("FAIL timeout_len: got %0d bus cycles, err %0d edges after request, want 16 and 17",
                 last_len, r.cnt - t0);
      end
      vectors++;
      if (r.dat !== last_lsu_dat) begin
        miscompares++;
        $display("FAIL timeout_dat_hold: got %h, want %h", r.dat, last_lsu_dat);
      end
    end
    repeat (3) tick();
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_single: got %0d extra pulses, want 0", got_q.size());
    end
    resp_mode = 0;
  endtask

  task automatic test_ack_err();
    rsp_t r;
    bit   ok;
    flush();
    resp_mode = 2; resp_delay = 1; resp_rdat = 32'h5A5A_5A5A;
    bus.if_addr_i = 32'h44; bus.if_req_i = 1'b1;
    wait_rsp(r, ok);
    bus.if_req_i = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ackerr_rsp: got no ack/err within 64 cycles, want if_err");
    end else begin
      vectors++;
      if ({r.lsu, r.err} !== 2'b01 || got_q.size() != 0) begin
        miscompares++;
        $display("FAIL ackerr_kind: got lsu=%b err=%b plus %0d more pulses, want lsu=0 err=1 only",
                 r.lsu, r.err, got_q.size());
      end
      vectors++;
      if (r.dat !== last_if_dat) begin
        miscompares++;
        $display("FAIL ackerr_dat_hold: got %h, want %h", r.dat, last_if_dat);
      end
    end
    repeat (3) tick();
    resp_mode = 0; resp_delay = 0;
  endtask

  task automatic test_stray();
    flush();
    resp_mode = 3;
    repeat (6) tick();
    vectors++;
    if (got_q.size() != 0 || bus.cyc_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stray: got %0d pulses cyc=%b, want 0 pulses cyc=0", got_q.size(), bus.cyc_o);
    end
    resp_mode = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    flush();
    resp_mode = 1;
    bus.lsu_we_i = 1'b1; bus.lsu_sel_i = 4'hF; bus.lsu_addr_i = 32'h400; bus.lsu_dat_i = 32'h4444_4444;
    bus.lsu_req_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = (bus.cyc_o === 1'b1);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rstmid_grant: got cyc=%b within 8 cycles, want 1", bus.cyc_o);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({bus.cyc_o, bus.stb_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_drop: got cyc=%b stb=%b, want 0 0", bus.cyc_o, bus.stb_o);
    end
    bus.lsu_req_i = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    vectors++;
    if (got_q.size() != 0 || bus.lsu_dat_o !== '0 || bus.if_dat_o !== '0) begin
      miscompares++;
      $display("FAIL rstmid_abort: got %0d pulses lsu_dat=%h if_dat=%h, want 0 pulses and zero data",
               got_q.size(), bus.lsu_dat_o, bus.if_dat_o);
    end
    last_if_dat = '0;
    last_lsu_dat = '0;
    lsu_write_check("rstmid_after", 32'h500, 4'b1100, 32'hCAFE_0001, 32'h0F0F_0F0F);
  endtask

  initial begin
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.lsu_req_i = 1'b0; bus.lsu_we_i = 1'b0; bus.lsu_sel_i = '0; bus.lsu_addr_i = '0; bus.lsu_dat_i = '0;
    test_reset();
    test_lsu_write();
    test_fetch_read();
    test_back_to_back();
    test_timeout();
    test_ack_err();
    test_stray();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
